sid_audio_out: RTL
==================

Name: sid_audio_out

Overview:
Output end of the SID mixed-sample path. Accepts the 15-bit offset-binary mixed sample from the SID filter/mixer on its sample strobe. Converts it to 16-bit two's complement and serialises it as mono (L = R) I2S to an external audio DAC. A single holding register decouples the SID sample rate from the I2S frame rate.

Parameters:
BCK_DIV, 4, clk cycles per half bit-clock period; legal range 1..255.
SLOT_W, 16, bits per channel slot; fixed at 16, exists only for package reuse.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
sample_in  in  15  mixed sample, offset binary, midscale 15'h4000
sample_strobe  in  1  one-clk pulse; sample_in valid (filter sample_ready qualified by clk_enable)
mute  in  1  forces transmitted word to 16'h0000
bck  out  1  I2S bit clock
lrck  out  1  I2S word select; 0 = left
sdata  out  1  I2S serial data, MSB first
frame_load  out  1  one-clk pulse when a word is loaded for transmission
overrun  out  1  sticky; a held sample was overwritten before being loaded
underrun  out  1  sticky; a frame started with no new sample (previous word repeated)

Behaviour:
- Reset (rst_n low at clk edge): bck = 0, lrck = 0, sdata = 0, frame_load = 0, overrun = 0, underrun = 0. Divider count, bit_cnt, holding register, hold_valid and tx word all cleared. Reset mid-frame aborts the frame; the first bck rise occurs BCK_DIV cycles after rst_n goes high.
- Conversion: word = {~s[14], s[13:0], 1'b0}.
  - 15'h4000 -> 16'h0000
  - 15'h7FFF -> 16'h7FFE
  - 15'h0000 -> 16'h8000
  - Bit 0 is always 0 unless dither is compiled in.
- Holding register: on sample_strobe, hold <= word and hold_valid <= 1. If hold_valid was already 1 and no load occurs in the same cycle, set overrun.
- Divider: counter 0..BCK_DIV-1. When it wraps, bck toggles. A bck 1->0 transition is the "fall event"; all data and lrck changes happen on fall events only.
- bit_cnt (5 bits, 0..31) increments on each fall event and wraps 31 -> 0.
  - lrck = bit_cnt[4].
  - Slot position p = bit_cnt[3:0]. p = 0 drives bit 0 of tx (standard I2S one-bit delay). p = 1..15 drive tx bits 15..1.
- Load on the fall event where bit_cnt becomes 1 (left-slot MSB):
  - hold_valid = 1: tx <= hold, hold_valid <= 0.
  - hold_valid = 0: tx unchanged, underrun <= 1.
  - mute = 1: tx <= 16'h0000 regardless.
  - frame_load pulses 1 clk on this event.
  - The right slot transmits the same tx.
- Strobe coinciding with load: the load takes the old hold, the new sample enters hold, hold_valid stays 1, no overrun.
- Frame length = 64*BCK_DIV clk cycles.

Optional Feature:
SID_AUDIO_OUT_DITHER_EN.
- Defined: a 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advances once per frame_load. Its bit 0 replaces tx bit 0 at load. Mute still forces 16'h0000.
- Undefined: no LFSR logic; bit 0 is always 0.

Decomposition:
- Package sid_audio_pkg:
  - SLOT_W = 16, FRAME_BITS = 32, MIDSCALE = 15'h4000
  - LFSR seed and taps
  - function sid_to_pcm16 (conversion above)
- Sub-module sid_bck_gen: BCK_DIV divider producing bck and a one-clk fall_evt.

Test Plan:
- Reset: rst_n low 3 clks mid-frame -> next clk bck/lrck/sdata/flags all 0. First bck rise BCK_DIV clks after release.
- Conversion (BCK_DIV=2): strobe 15'h7FFF -> frame_load, left slot serialises 16'h7FFE MSB first on bit_cnt 1..15, then bit 0 at bit_cnt 16. Repeat for 15'h4000 -> 16'h0000 and 15'h0000 -> 16'h8000.
- Overrun: strobes 15'h5000 then 15'h6000 within one frame, no load between -> next frame sends 16'h4000, overrun = 1.
- Underrun: one strobe 15'h5000, then none for 2 frames -> 16'h2000 sent 3 times, underrun = 1 after the second load.
- Mute: mute = 1 with pending 15'h7FFF -> loaded word 16'h0000, hold_valid cleared.
- Simultaneous strobe and load: strobe exactly on the load clk -> previous hold transmitted, new sample sent next frame, overrun stays 0.

Source files
------------

// File: rtl/sid_audio_pkg.sv
`default_nettype none
// sid_audio_pkg: shared constants and sample conversion for the SID audio output path.
// Rev 1.0
package sid_audio_pkg;
  localparam int          SLOT_W     = 16;
  localparam int          FRAME_BITS = 32;
  localparam logic [14:0] MIDSCALE   = 15'h4000;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  // Galois right-shift form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  function automatic logic [15:0] sid_to_pcm16(input logic [14:0] s);
    return {~s[14], s[13:0], 1'b0};
  endfunction
endpackage
`default_nettype wire

// File: rtl/sid_bck_gen.sv
`default_nettype none
// sid_bck_gen: divides clk by 2*BCK_DIV into the I2S bit clock; flags each bck fall.
// Rev 1.0
module sid_bck_gen #(
  parameter int BCK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic bck,
  output logic fall_evt
);
  logic [7:0] cnt_q, cnt_d;
  logic       bck_q, bck_d;
  logic       w_wrap;

  assign w_wrap = (cnt_q == 8'(BCK_DIV - 1));

  always_comb begin
    cnt_d = w_wrap ? 8'd0 : cnt_q + 8'd1;
    bck_d = w_wrap ? ~bck_q : bck_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
      bck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      bck_q <= bck_d;
    end
  end

  assign bck      = bck_q;
  assign fall_evt = w_wrap & bck_q;
endmodule
`default_nettype wire

// File: rtl/sid_audio_out.sv
`default_nettype none
// sid_audio_out: SID mixed sample -> 16-bit two's complement mono I2S. Rev 1.0
// Optional LSB dither from a 16-bit LFSR when SID_AUDIO_OUT_DITHER_EN is defined.
import sid_audio_pkg::*;

module sid_audio_out #(
  parameter int BCK_DIV = 4,
  parameter int SLOT_W  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [14:0] sample_in,
  input  logic        sample_strobe,
  input  logic        mute,
  output logic        bck,
  output logic        lrck,
  output logic        sdata,
  output logic        frame_load,
  output logic        overrun,
  output logic        underrun
);
  localparam int CNT_W = $clog2(FRAME_BITS);

  logic              w_fall;
  logic              w_load;
  logic [3:0]        w_idx;
  logic [SLOT_W-1:0] w_load_word;

  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [SLOT_W-1:0] hold_q, hold_d;
  logic [SLOT_W-1:0] tx_q, tx_d;
  logic              hold_valid_q, hold_valid_d;
  logic              sdata_q, sdata_d;
  logic              frame_load_q, frame_load_d;
  logic              overrun_q, overrun_d;
  logic              underrun_q, underrun_d;

  sid_bck_gen #(.BCK_DIV(BCK_DIV)) u_bck_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .bck      (bck),
    .fall_evt (w_fall)
  );

  assign w_load = w_fall && (bit_cnt_q == '0);
  // Slot position p selects tx bit (16 - p) mod 16, so p = 0 carries the delayed LSB.
  assign w_idx  = 4'd0 - bit_cnt_d[3:0];

`ifdef SID_AUDIO_OUT_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d      = w_load ? ({1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000))
                              : lfsr_q;
  assign w_load_word = {hold_q[SLOT_W-1:1], lfsr_q[0]};

  always_ff @(posedge clk) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end
`else
  assign w_load_word = hold_q;
`endif

  always_comb begin
    bit_cnt_d    = w_fall ? bit_cnt_q + CNT_W'(1) : bit_cnt_q;
    tx_d         = tx_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    overrun_d    = overrun_q;
    underrun_d   = underrun_q;
    frame_load_d = w_load;

    if (w_load) begin
      if (mute)              tx_d = '0;
      else if (hold_valid_q) tx_d = w_load_word;
      if (!hold_valid_q) underrun_d = 1'b1;
      hold_valid_d = 1'b0;
    end

    // A strobe on the load cycle refills hold after the old word has been taken.
    if (sample_strobe) begin
      hold_d       = sid_to_pcm16(sample_in);
      hold_valid_d = 1'b1;
      if (hold_valid_q && !w_load) overrun_d = 1'b1;
    end

    sdata_d = w_fall ? tx_d[w_idx] : sdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt_q    <= '0;
      hold_q       <= '0;
      tx_q         <= '0;
      hold_valid_q <= 1'b0;
      sdata_q      <= 1'b0;
      frame_load_q <= 1'b0;
      overrun_q    <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      hold_q       <= hold_d;
      tx_q         <= tx_d;
      hold_valid_q <= hold_valid_d;
      sdata_q      <= sdata_d;
      frame_load_q <= frame_load_d;
      overrun_q    <= overrun_d;
      underrun_q   <= underrun_d;
    end
  end

  assign lrck       = bit_cnt_q[CNT_W-1];
  assign sdata      = sdata_q;
  assign frame_load = frame_load_q;
  assign overrun    = overrun_q;
  assign underrun   = underrun_q;
endmodule
`default_nettype wire
